// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding, frame-counter width and default geometry
package cam_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} cap_state_t;
  localparam int FRAME_W = 8;
  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_ADDR_WIDTH = 19;
endpackage

// File: rtl/cam_capture_ctrl_det_edge.sv
// DET_EDGE: one-register change detector on a single-bit level
//   CLK, RST_N : clock, async active-low reset
//   iD         : level to watch
//   oEDGE      : high in any cycle where iD differs from its previous value
module DET_EDGE (
  input  logic CLK,
  input  logic RST_N,
  input  logic iD,
  output logic oEDGE
);
  logic d_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) d_q <= 1'b0;
    else d_q <= iD;
  assign oEDGE = iD ^ d_q;
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-capture FSM driving a double-buffered frame memory
//   CLK, RST_N                  : clock, async active-low reset
//   iVSYNC/iDE/iFIELD/iDATA_L/R : registered video stream
//   iSTART/iSTOP/iNUM_FRAMES    : run control (NUM_FRAMES 0 = continuous)
//   iFIELD_EN/iFIELD_SEL        : field filter
//   oWE/oWADDR/oWDATA/oBANK     : frame-memory write port
//   oBUSY/oDONE/oFRAMES         : host status
//   oERR_H/oERR_V               : sticky geometry errors
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     iVSYNC,
  input  logic                     iDE,
  input  logic                     iFIELD,
  input  logic [PIXEL_WIDTH-1:0]   iDATA_L,
  input  logic [PIXEL_WIDTH-1:0]   iDATA_R,
  input  logic                     iSTART,
  input  logic                     iSTOP,
  input  logic [FRAME_W-1:0]       iNUM_FRAMES,
  input  logic                     iFIELD_EN,
  input  logic                     iFIELD_SEL,
  output logic                     oWE,
  output logic [ADDR_WIDTH-1:0]    oWADDR,
  output logic [2*PIXEL_WIDTH-1:0] oWDATA,
  output logic                     oBANK,
  output logic                     oBUSY,
  output logic                     oDONE,
  output logic [FRAME_W-1:0]       oFRAMES,
  output logic                     oERR_H,
  output logic                     oERR_V
);
  localparam int PCW = $clog2(H_ACTIVE + 1);
  localparam int LCW = $clog2(V_ACTIVE + 2);
  localparam logic [PCW-1:0] H_LIM = PCW'(H_ACTIVE);
  localparam logic [LCW-1:0] V_LIM = LCW'(V_ACTIVE);
  cap_state_t state;
  logic [PCW-1:0] pix_cnt;
  logic [LCW-1:0] line_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [FRAME_W-1:0] num_frames;
  logic field_en, field_sel, stop_pend;
  logic vs_edge, de_edge, vs_rise, vs_fall, de_fall;
  DET_EDGE u_vs (.CLK(CLK), .RST_N(RST_N), .iD(iVSYNC), .oEDGE(vs_edge));
  DET_EDGE u_de (.CLK(CLK), .RST_N(RST_N), .iD(iDE), .oEDGE(de_edge));
  assign vs_rise = vs_edge & iVSYNC;
  assign vs_fall = vs_edge & ~iVSYNC;
  assign de_fall = de_edge & ~iDE;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      addr       <= '0;
      num_frames <= '0;
      field_en   <= 1'b0;
      field_sel  <= 1'b0;
      stop_pend  <= 1'b0;
      oWE        <= 1'b0;
      oWADDR     <= '0;
      oWDATA     <= '0;
      oBANK      <= 1'b0;
      oBUSY      <= 1'b0;
      oDONE      <= 1'b0;
      oFRAMES    <= '0;
      oERR_H     <= 1'b0;
      oERR_V     <= 1'b0;
    end else begin
      oWE   <= 1'b0;
      oDONE <= 1'b0;
      case (state)
        IDLE: if (iSTART && !iSTOP) begin
          state      <= ARMED;
          oBUSY      <= 1'b1;
          oFRAMES    <= '0;
          oERR_H     <= 1'b0;
          oERR_V     <= 1'b0;
          num_frames <= iNUM_FRAMES;
          field_en   <= iFIELD_EN;
          field_sel  <= iFIELD_SEL;
          stop_pend  <= 1'b0;
        end
        ARMED:
          if (iSTOP) begin
            state <= DONE;
            oDONE <= 1'b1;
          end else if (vs_fall && !(field_en && iFIELD != field_sel)) begin
            state    <= CAPTURE;
            pix_cnt  <= '0;
            line_cnt <= '0;
            addr     <= '0;
          end
        CAPTURE: begin
          if (iSTOP) stop_pend <= 1'b1;
          // line overflow takes precedence: once past the last line every pixel is a V error
          if (iDE) begin
            if (line_cnt >= V_LIM) oERR_V <= 1'b1;
            else if (pix_cnt >= H_LIM) oERR_H <= 1'b1;
            else begin
              oWE     <= 1'b1;
              oWADDR  <= addr;
              oWDATA  <= {iDATA_R, iDATA_L};
              addr    <= addr + 1'b1;
              pix_cnt <= pix_cnt + 1'b1;
            end
          end
          if (de_fall) begin
            if (pix_cnt != H_LIM) oERR_H <= 1'b1;
            if (line_cnt <= V_LIM) line_cnt <= line_cnt + 1'b1;
            pix_cnt <= '0;
          end
          if (vs_rise) begin
            if (line_cnt != V_LIM) oERR_V <= 1'b1;
            oFRAMES <= oFRAMES + 1'b1;
            oBANK   <= ~oBANK;
            if (stop_pend || iSTOP || (num_frames != '0 && oFRAMES + 1'b1 == num_frames)) begin
              state <= DONE;
              oDONE <= 1'b1;
            end else state <= ARMED;
          end
        end
        DONE: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
